// File: rtl/led_pwm_array.sv
// Multi-channel LED PWM driver: shared tick divider and PWM counter, with
// per-channel off / static / breathe / blink behaviour and a power-on hold.
module led_pwm_array #(
    parameter int CHANNELS   = 3,
    parameter int PWM_BITS   = 8,
    parameter int DIV_BITS   = 11,
    parameter int POR_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DIV_BITS-1:0]          speed,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic [PWM_BITS*CHANNELS-1:0] level,
    output logic [CHANNELS-1:0]          led,
    output logic                         period
);

    localparam int                  MAX_I    = (2 ** PWM_BITS) - 1;
    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam int                  POR_W    = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam logic [POR_W-1:0]    POR_LAST = POR_W'(POR_CYCLES - 1);

    localparam logic [1:0] M_OFF     = 2'b00;
    localparam logic [1:0] M_STATIC  = 2'b01;
    localparam logic [1:0] M_BREATHE = 2'b10;
    localparam logic [1:0] M_BLINK   = 2'b11;

    // Power-on hold lives outside the rst domain: its start value comes from
    // device configuration and only power cycling restarts it.
    logic [POR_W-1:0] por_cnt_q = '0;
    logic             por_done_q = 1'b0;
    logic [POR_W-1:0] por_cnt_d;
    logic             por_done_d;

    logic [DIV_BITS-1:0]                div_cnt_q, div_cnt_d;
    logic [PWM_BITS-1:0]                pwm_cnt_q, pwm_cnt_d;
    logic [CHANNELS-1:0]                led_q, led_d;
    logic                               period_q, period_d;
    logic [CHANNELS-1:0]                blink_q, blink_d;
    logic [CHANNELS-1:0]                dir_up_q, dir_up_d;
    logic [CHANNELS-1:0][PWM_BITS-1:0]  duty_q, duty_d;
    logic [CHANNELS-1:0][PWM_BITS-1:0]  step;

    logic hold;
    logic tick;

    assign hold   = !rst || !por_done_q;
    assign tick   = (div_cnt_q == '0);
    assign led    = led_q;
    assign period = period_q;

    // Power-on counter: runs once, then latches done forever.
    always_comb begin
        por_cnt_d  = por_cnt_q;
        por_done_d = por_done_q;
        if (!por_done_q) begin
            if (por_cnt_q == POR_LAST) begin
                por_done_d = 1'b1;
            end else begin
                por_cnt_d = por_cnt_q + 1'b1;
            end
        end
    end

    // Candidate breathe duty one step along the current direction.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            step[i] = dir_up_q[i] ? (duty_q[i] + 1'b1) : (duty_q[i] - 1'b1);
        end
    end

    // Divider, shared PWM counter and per-channel output/breathe/blink state.
    always_comb begin
        div_cnt_d = div_cnt_q;
        pwm_cnt_d = pwm_cnt_q;
        led_d     = led_q;
        period_d  = 1'b0;
        blink_d   = blink_q;
        dir_up_d  = dir_up_q;
        duty_d    = duty_q;
        if (hold) begin
            div_cnt_d = '0;
            pwm_cnt_d = '0;
            led_d     = '0;
            blink_d   = '0;
            dir_up_d  = '1;
            for (int i = 0; i < CHANNELS; i++) begin
                // Staggered starting duties so breathing channels are out of phase.
                duty_d[i] = PWM_BITS'((i * MAX_I) / CHANNELS);
            end
        end else begin
            div_cnt_d = (div_cnt_q >= speed) ? '0 : div_cnt_q + 1'b1;
            if (tick) begin
                pwm_cnt_d = pwm_cnt_q + 1'b1;
                period_d  = (pwm_cnt_q == MAX);
                for (int i = 0; i < CHANNELS; i++) begin
                    case (mode[2*i +: 2])
                        M_OFF:     led_d[i] = 1'b0;
                        M_STATIC:  led_d[i] = (pwm_cnt_q <= level[PWM_BITS*i +: PWM_BITS]);
                        M_BREATHE: led_d[i] = (pwm_cnt_q <= duty_q[i]);
                        M_BLINK:   led_d[i] = blink_q[i];
                        default:   led_d[i] = 1'b0;
                    endcase
                    if (pwm_cnt_q == MAX) begin
                        blink_d[i] = ~blink_q[i];
                    end
                    if ((mode[2*i +: 2] == M_BREATHE) && (pwm_cnt_q == '0)) begin
                        duty_d[i] = step[i];
                        if ((step[i] == MAX) || (step[i] == '0)) begin
                            dir_up_d[i] = ~dir_up_q[i];
                        end
                    end
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        por_cnt_q  <= por_cnt_d;
        por_done_q <= por_done_d;
        div_cnt_q  <= div_cnt_d;
        pwm_cnt_q  <= pwm_cnt_d;
        led_q      <= led_d;
        period_q   <= period_d;
        blink_q    <= blink_d;
        dir_up_q   <= dir_up_d;
        duty_q     <= duty_d;
    end

endmodule

// File: doc/led_pwm_array.md
LED_PWM_ARRAY -- requirements
Module: led_pwm_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, number of independent LED outputs (1..16).
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM/duty resolution; MAX = 2^PWM_BITS-1.
REQ-003 SHALL have parameter DIV_BITS, default 11, width of the tick divider.
REQ-004 SHALL have parameter POR_CYCLES, default 256, internal power-on hold length in clk cycles.
REQ-005 SHALL have port clk  input  1  rising-edge clock for all logic.
REQ-006 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-007 SHALL have port speed  input  DIV_BITS  tick divider terminal count.
REQ-008 SHALL have port mode  input  2*CHANNELS  per channel [2i+1:2i]: 00 off, 01 static, 10 breathe, 11 blink.
REQ-009 SHALL have port level  input  PWM_BITS*CHANNELS  per channel static duty.
REQ-010 SHALL have port led  output  CHANNELS  registered PWM outputs.
REQ-011 SHALL have port period  output  1  one-cycle pulse marking each PWM period end.

Function
REQ-012 Divider: div_cnt increments each cycle; it SHALL load 0 when div_cnt >= speed, so a tick occurs once every speed+1 cycles (every cycle when speed = 0); a speed decrease below div_cnt wraps on the next cycle.
REQ-013 Tick SHALL be asserted in the cycle with div_cnt == 0; all state below changes only on tick.
REQ-014 pwm_cnt SHALL advance 0..MAX on each tick and wrap MAX -> 0, shared by all channels.
REQ-015 period SHALL pulse high for exactly one cycle on the tick where pwm_cnt wraps MAX -> 0.
REQ-016 Each channel SHALL hold an effective duty d: breathe -> internal duty register; static -> level slice; off/blink -> not used.
REQ-017 On tick, led[i] SHALL register: off -> 0; static/breathe -> (pwm_cnt <= d); blink -> blink_state[i].
REQ-018 Breathe: on the tick with pwm_cnt == 0, duty SHALL step +1 (dir up) or -1 (dir down) in PWM_BITS arithmetic, registered in the same cycle; no other cycle modifies duty.
REQ-019 Breathe: if the stepped value equals MAX or 0, dir SHALL invert in that same cycle; duty never wraps past MAX or below 0.
REQ-020 Blink: blink_state[i] SHALL toggle on every period pulse; initial value 0.
REQ-021 Mode changes SHALL take effect on the next tick; entering breathe keeps the existing duty and dir.
REQ-022 static level changes SHALL be sampled continuously; level = MAX gives led constantly 1, level = 0 gives led 1 only in the pwm_cnt == 0 slot.
REQ-023 Channels SHALL be fully independent apart from the shared divider and pwm_cnt.

Reset
REQ-024 An internal POR counter SHALL count from 0 to POR_CYCLES-1 after configuration, then set por_done permanently; rst does not clear it.
REQ-025 While rst == 0 or por_done == 0: div_cnt = 0, pwm_cnt = 0, led = 0, period = 0, blink_state = 0, dir = up, and duty[i] = (i*MAX)/CHANNELS (integer division), giving phase-staggered breathing.
REQ-026 Reset asserted mid-period SHALL take effect on the next rising clock edge, discarding partial state; the first tick after release occurs in the first cycle after release.

Verification
REQ-027 CHANNELS=3, PWM_BITS=8, speed=0, rst released after POR: duty = {0,85,170}; after one period, led[1] high for 86 ticks, led[2] high for 171.
REQ-028 Breathe ch0, speed=0: duty climbs 0..255 one step per 256-cycle period, dir inverts at 255, then descends to 0 and inverts again; never 256/-1.
REQ-029 speed=4: ticks spaced exactly 5 cycles; period pulse every 1280 cycles, one cycle wide.
REQ-030 Static mode, level=0 -> led high 1 tick per period; level=255 -> led constantly high; level=128 -> high 129 ticks.
REQ-031 Blink ch2: led[2] toggles every period pulse; mode 00 forces led low on the next tick.
REQ-032 Drop rst to 0 mid-breathe for one cycle: next cycle all outputs 0, duty reloads {0,85,170}; por_done remains set.
